// File: rtl/encoder_pkg.sv
// Shared op kinds, condition nibbles and opcode prefixes for the ARM-subset encoder.
// The control-unit bench imports the same constants so both sides agree on encodings.
package encoder_pkg;

  typedef enum logic [4:0] {
    OpMovR, OpLslI, OpLslR, OpMovI, OpAddR, OpAddI, OpSubR, OpSubI, OpMul,
    OpAndI, OpCmpR, OpCmpI, OpLdrI, OpLdrR, OpStrI, OpPush, OpPop, OpBx,
    OpB, OpBeq, OpBne, OpBgt, OpBlt, OpBge, OpBle, OpBl
  } op_e;

  typedef enum logic [1:0] {ErrNone, ErrIllegal, ErrImm, ErrBranch} err_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [3:0] REG_SP = 4'hD;

  localparam logic [11:0] OPC_MOV_R = 12'hE1A;
  localparam logic [11:0] OPC_MOV_I = 12'hE3A;
  localparam logic [11:0] OPC_ADD_R = 12'hE08;
  localparam logic [11:0] OPC_ADD_I = 12'hE28;
  localparam logic [11:0] OPC_SUB_R = 12'hE04;
  localparam logic [11:0] OPC_SUB_I = 12'hE24;
  localparam logic [11:0] OPC_MUL   = 12'hE00;
  localparam logic [11:0] OPC_AND_I = 12'hE20;
  localparam logic [11:0] OPC_CMP_R = 12'hE15;
  localparam logic [11:0] OPC_CMP_I = 12'hE35;
  localparam logic [11:0] OPC_LDR_I = 12'hE59;
  localparam logic [11:0] OPC_LDR_R = 12'hE79;
  localparam logic [11:0] OPC_STR_I = 12'hE58;
  localparam logic [11:0] OPC_PUSH  = 12'hE52;
  localparam logic [11:0] OPC_POP   = 12'hE49;
  localparam logic [31:0] INSN_BX   = 32'hE12FFF1E;

  function automatic logic [3:0] branch_cond(op_e op);
    case (op)
      OpBeq:   return COND_EQ;
      OpBne:   return COND_NE;
      OpBgt:   return COND_GT;
      OpBlt:   return COND_LT;
      OpBge:   return COND_GE;
      OpBle:   return COND_LE;
      default: return COND_AL;
    endcase
  endfunction

endpackage

// File: rtl/instr_word_format.sv
// Combinational field packer: op + fields + word-address pc -> 32-bit machine word,
// plus immediate and branch-range checks.
module instr_word_format
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [4:0]        op,
  input  logic [3:0]        rd,
  input  logic [3:0]        rn,
  input  logic [3:0]        rm,
  input  logic [3:0]        rs,
  input  logic [11:0]       imm,
  input  logic [ADDR_W+1:0] target,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       word,
  output err_e              err_code
);

  op_e                opd;
  logic signed [33:0] diff;
  logic signed [33:0] off;
  logic               branch_ok;

  assign opd = op_e'(op);

  // Branch offset is relative to pc+8, in words, and must fit signed 24 bits.
  always_comb begin
    diff      = $signed(34'(target)) - $signed(34'({pc, 2'b00})) - 34'sd8;
    off       = diff >>> 2;
    branch_ok = (target[1:0] == 2'b00) && (off[33:23] == {11{off[23]}});
  end

  always_comb begin
    word     = 32'h0;
    err_code = ErrNone;
    case (opd)
      OpMovR: word = {OPC_MOV_R, 4'h0, rd, 8'h00, rm};
      OpLslI: begin
        word = {OPC_MOV_R, 4'h0, rd, imm[4:0], 3'b000, rm};
        if (imm[11:5] != 7'd0 || imm[4:0] == 5'd0) err_code = ErrImm;
      end
      OpLslR: word = {OPC_MOV_R, 4'h0, rd, rs, 4'h1, rm};
      OpMovI: word = {OPC_MOV_I, 4'h0, rd, imm};
      OpAddR: word = {OPC_ADD_R, rn, rd, 8'h00, rm};
      OpAddI: word = {OPC_ADD_I, rn, rd, imm};
      OpSubR: word = {OPC_SUB_R, rn, rd, 8'h00, rm};
      OpSubI: word = {OPC_SUB_I, rn, rd, imm};
      OpMul:  word = {OPC_MUL, rd, 4'h0, rs, 4'h9, rm};
      OpAndI: word = {OPC_AND_I, rn, rd, imm};
      OpCmpR: word = {OPC_CMP_R, rn, 4'h0, 8'h00, rm};
      OpCmpI: word = {OPC_CMP_I, rn, 4'h0, imm};
      OpLdrI: word = {OPC_LDR_I, rn, rd, imm};
      OpLdrR: word = {OPC_LDR_R, rn, rd, 8'h00, rm};
      OpStrI: word = {OPC_STR_I, rn, rd, imm};
      OpPush: word = {OPC_PUSH, REG_SP, rd, 12'h004};
      OpPop:  word = {OPC_POP, REG_SP, rd, 12'h004};
      OpBx:   word = INSN_BX;
      OpB, OpBeq, OpBne, OpBgt, OpBlt, OpBge, OpBle, OpBl: begin
        word = {branch_cond(opd), (opd == OpBl) ? 4'hB : 4'hA, off[23:0]};
        if (!branch_ok) err_code = ErrBranch;
      end
      default: err_code = ErrIllegal;
    endcase
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Accepts decoded instruction requests, encodes them and writes the words sequentially
// into instruction memory through a we/ack handshake.
module instr_word_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [3:0]        in_rs,
  input  logic [11:0]       in_imm,
  input  logic [ADDR_W+1:0] in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0] PtrBase = (ADDR_W + 1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] PtrEnd  = (ADDR_W + 1)'(BASE_ADDR + 2 ** ADDR_W);

  typedef enum logic [1:0] {StIdle, StEnc, StWrite} state_e;

  state_e            state_q;
  logic              ready_q;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W:0]   ptr_inc;
  logic [4:0]        op_q;
  logic [3:0]        rd_q, rn_q, rm_q, rs_q;
  logic [11:0]       imm_q;
  logic [ADDR_W+1:0] target_q;
  logic [31:0]       fmt_word;
  err_e              fmt_err;

  // start wins over a simultaneous request, so it must also mask the handshake.
  assign in_ready = ready_q & ~start;
  assign mem_addr = ptr_q[ADDR_W-1:0];
  assign ptr_inc  = ptr_q + 1'b1;

  instr_word_format #(
    .ADDR_W(ADDR_W)
  ) u_format (
    .op       (op_q),
    .rd       (rd_q),
    .rn       (rn_q),
    .rm       (rm_q),
    .rs       (rs_q),
    .imm      (imm_q),
    .target   (target_q),
    .pc       (ptr_q[ADDR_W-1:0]),
    .word     (fmt_word),
    .err_code (fmt_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      ptr_q     <= PtrBase;
      mem_we    <= 1'b0;
      mem_wdata <= 32'h0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      op_q      <= 5'd0;
      rd_q      <= 4'd0;
      rn_q      <= 4'd0;
      rm_q      <= 4'd0;
      rs_q      <= 4'd0;
      imm_q     <= 12'd0;
      target_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ptr_q    <= PtrBase;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            ready_q  <= 1'b1;
          end else if (in_valid && ready_q) begin
            op_q     <= in_op;
            rd_q     <= in_rd;
            rn_q     <= in_rn;
            rm_q     <= in_rm;
            rs_q     <= in_rs;
            imm_q    <= in_imm;
            target_q <= in_target;
            ready_q  <= 1'b0;
            state_q  <= StEnc;
          end else begin
            ready_q <= ~full;
          end
        end
        StEnc: begin
          mem_wdata <= fmt_word;
          if (fmt_err != ErrNone) begin
            if (!err) begin
              err      <= 1'b1;
              err_code <= fmt_err;
            end
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            mem_we  <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (mem_ack) begin
            mem_we  <= 1'b0;
            ptr_q   <= ptr_inc;
            count   <= count + 1'b1;
            full    <= (ptr_inc == PtrEnd);
            ready_q <= (ptr_inc != PtrEnd);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Table-driven bench for instr_word_encoder with a write scoreboard and an ack responder.
module tb_instr_word_encoder;
  import encoder_pkg::*;

  localparam int unsigned AW = 10;

  typedef struct {
    logic        st;
    logic [4:0]  op;
    logic [3:0]  rd, rn, rm, rs;
    logic [11:0] imm;
    logic [11:0] tgt;
    int          dly;
    logic        we;
    logic [31:0] word;
    logic [1:0]  ec;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready;
  logic [4:0]    in_op;
  logic [3:0]    in_rd, in_rn, in_rm, in_rs;
  logic [11:0]   in_imm;
  logic [AW+1:0] in_target;
  logic          mem_we, mem_ack, full, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic [1:0]    err_code;

  int  checks = 0;
  int  errors = 0;
  int  ack_delay = 0;
  wr_t sb_q[$];
  int  ptr_m = 0, count_m = 0;
  logic err_m = 1'b0, full_m = 1'b0;
  logic [1:0] code_m = 2'd0;

  always #5 clk = ~clk;

  instr_word_encoder #(
    .ADDR_W    (AW),
    .BASE_ADDR (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_rs     (in_rs),
    .in_imm    (in_imm),
    .in_target (in_target),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .count     (count),
    .full      (full),
    .err       (err),
    .err_code  (err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic st, logic [4:0] op, logic [3:0] rd, logic [3:0] rn,
                              logic [3:0] rm, logic [3:0] rs, logic [11:0] imm,
                              logic [11:0] tgt, int dly, logic we, logic [31:0] word,
                              logic [1:0] ec);
    vec_t v;
    v.st = st; v.op = op; v.rd = rd; v.rn = rn; v.rm = rm; v.rs = rs;
    v.imm = imm; v.tgt = tgt; v.dly = dly; v.we = we; v.word = word; v.ec = ec;
    return v;
  endfunction

  // Ack responder and scoreboard: every acked write must match the oldest expected entry.
  initial begin
    int wcnt;
    wr_t e;
    wcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        if (wcnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (sb_q.size() == 0) begin
            check("unexpected_write", {22'd0, mem_addr}, 32'hFFFFFFFF);
          end else begin
            e = sb_q.pop_front();
            check("wr_addr", {22'd0, mem_addr}, {22'd0, e.addr});
            check("wr_data", mem_wdata, e.data);
          end
        end else begin
          mem_ack = 1'b0;
        end
        wcnt++;
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic send(input vec_t v);
    int  n;
    wr_t w;
    if (v.st) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ptr_m = 0; count_m = 0; err_m = 1'b0; code_m = 2'd0; full_m = 1'b0;
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before", {31'd0, in_ready}, 32'd1);
    in_op = v.op; in_rd = v.rd; in_rn = v.rn; in_rm = v.rm; in_rs = v.rs;
    in_imm = v.imm; in_target = v.tgt; ack_delay = v.dly; in_valid = 1'b1;
    if (v.we) begin
      w.addr = ptr_m[AW-1:0];
      w.data = v.word;
      sb_q.push_back(w);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (v.we) begin
      ptr_m++;
      count_m++;
      full_m = (count_m == 1024);
    end else if (v.ec != 2'd0 && !err_m) begin
      err_m = 1'b1;
      code_m = v.ec;
    end
    n = 0;
    if (full_m) begin
      repeat (2 + v.dly) @(negedge clk);
    end else begin
      while (in_ready !== 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
      end
      check("busy_cycles", n, v.we ? 32'(2 + v.dly) : 32'd1);
    end
    check("count", {21'd0, count}, count_m);
    check("err", {31'd0, err}, {31'd0, err_m});
    check("err_code", {30'd0, err_code}, {30'd0, code_m});
    check("full", {31'd0, full}, {31'd0, full_m});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[26];
    int   n;
    vecs[0]  = mk(1, OpB,    0, 0, 0, 0, 12'h000, 12'h010, 0, 1, 32'hEA000002, 0);
    vecs[1]  = mk(0, OpAddR, 2, 1, 3, 0, 12'h000, 12'h000, 3, 1, 32'hE0812003, 0);
    vecs[2]  = mk(0, OpMul,  0, 0, 1, 2, 12'h000, 12'h000, 0, 1, 32'hE0000291, 0);
    vecs[3]  = mk(0, OpLslR, 0, 0, 1, 2, 12'h000, 12'h000, 0, 1, 32'hE1A00211, 0);
    vecs[4]  = mk(0, OpBl,   0, 0, 0, 0, 12'h000, 12'h000, 0, 1, 32'hEBFFFFFA, 0);
    vecs[5]  = mk(0, OpBx,   0, 0, 0, 0, 12'h000, 12'h000, 0, 1, 32'hE12FFF1E, 0);
    vecs[6]  = mk(0, OpPush, 4, 0, 0, 0, 12'h000, 12'h000, 0, 1, 32'hE52D4004, 0);
    vecs[7]  = mk(0, OpPop,  4, 0, 0, 0, 12'h000, 12'h000, 0, 1, 32'hE49D4004, 0);
    vecs[8]  = mk(0, OpBne,  0, 0, 0, 0, 12'h000, 12'h000, 0, 1, 32'h1AFFFFF6, 0);
    vecs[9]  = mk(0, OpSubI, 3, 2, 0, 0, 12'h0FF, 12'h000, 1, 1, 32'hE24230FF, 0);
    vecs[10] = mk(0, OpLdrR, 2, 1, 3, 0, 12'h000, 12'h000, 0, 1, 32'hE7912003, 0);
    vecs[11] = mk(0, OpCmpI, 0, 5, 0, 0, 12'h012, 12'h000, 0, 1, 32'hE3550012, 0);
    vecs[12] = mk(0, OpLslI, 1, 0, 2, 0, 12'h003, 12'h000, 0, 1, 32'hE1A01182, 0);
    vecs[13] = mk(0, OpLslI, 1, 0, 2, 0, 12'h040, 12'h000, 0, 0, 32'h0, 2);
    vecs[14] = mk(0, OpMovR, 1, 0, 2, 0, 12'h000, 12'h000, 0, 1, 32'hE1A01002, 0);
    vecs[15] = mk(0, 5'd31,  0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 32'h0, 1);
    vecs[16] = mk(0, OpB,    0, 0, 0, 0, 12'h000, 12'h002, 0, 0, 32'h0, 3);
    vecs[17] = mk(1, OpLslI, 1, 0, 2, 0, 12'h000, 12'h000, 0, 0, 32'h0, 2);
    vecs[18] = mk(1, OpBeq,  0, 0, 0, 0, 12'h000, 12'h006, 0, 0, 32'h0, 3);
    vecs[19] = mk(1, OpStrI, 0, 13, 0, 0, 12'h004, 12'h000, 0, 1, 32'hE58D0004, 0);
    vecs[20] = mk(0, OpAndI, 2, 1, 0, 0, 12'h0F0, 12'h000, 2, 1, 32'hE20120F0, 0);
    vecs[21] = mk(0, OpCmpR, 0, 1, 2, 0, 12'h000, 12'h000, 0, 1, 32'hE1510002, 0);
    vecs[22] = mk(0, 5'd26,  0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 32'h0, 1);
    vecs[23] = mk(0, OpLdrI, 1, 13, 0, 0, 12'h008, 12'h000, 0, 1, 32'hE59D1008, 0);
    vecs[24] = mk(0, OpAddI, 0, 0, 0, 0, 12'hFFF, 12'h000, 0, 1, 32'hE2800FFF, 0);
    vecs[25] = mk(0, OpSubR, 5, 4, 6, 0, 12'h000, 12'h000, 0, 1, 32'hE0445006, 0);

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_op = 5'd0;
    in_rd = 4'd0; in_rn = 4'd0; in_rm = 4'd0; in_rs = 4'd0; in_imm = 12'd0; in_target = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_count", {21'd0, count}, 32'd0);
    check("rst_full_err", {29'd0, full, err, |err_code}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // MOV_I r1,#5: write strobe must first appear two cycles after accept.
    in_op = OpMovI; in_rd = 4'd1; in_imm = 12'd5; ack_delay = 0; in_valid = 1'b1;
    sb_q.push_back('{addr: '0, data: 32'hE3A01005});
    @(negedge clk);
    in_valid = 1'b0;
    check("we_cycle_n1", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("we_cycle_n2", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    check("movi_count", {21'd0, count}, 32'd1);
    check("movi_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 26; i++) send(vecs[i]);

    // start and a request in the same cycle: start wins, nothing is accepted.
    start = 1'b1; in_valid = 1'b1; in_op = OpMovI;
    #1;
    check("start_masks_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    ptr_m = 0; count_m = 0; err_m = 1'b0; code_m = 2'd0; full_m = 1'b0;
    repeat (4) @(negedge clk);
    check("start_prio_count", {21'd0, count}, 32'd0);
    check("start_prio_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 1024; i++)
      send(mk(0, OpMovI, 4'(i), 0, 0, 0, 12'(i), 12'h000, 0, 1,
              {16'hE3A0, 4'(i), 12'(i)}, 0));
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("full_count", {21'd0, count}, 32'd1024);
    check("full_addr_wrap", {22'd0, mem_addr}, 32'd0);
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("full_no_accept", {21'd0, count}, 32'd1024);
    check("full_no_we", {31'd0, mem_we}, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);

    send(mk(1, OpMovI, 2, 0, 0, 0, 12'h07, 12'h000, 0, 1, 32'hE3A02007, 0));

    // Write stalled by memory, then reset lands mid-WRITE.
    ack_delay = 1000;
    in_op = OpMovI; in_rd = 4'd3; in_imm = 12'h3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (mem_we !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("stall_we", {31'd0, mem_we}, 32'd1);
    check("stall_count", {21'd0, count}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_we", {31'd0, mem_we}, 32'd0);
    check("rst_mid_count", {21'd0, count}, 32'd0);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    check("ready_after_rst2", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_word_encoder.md
Name: instr_word_encoder

Overview:
- Encodes decoded instruction requests (op kind plus register, immediate and target fields) into 32-bit ARM-subset machine words.
- Writes each word sequentially into instruction memory through a write handshake.
- It is the encoder counterpart of the processor's control-unit decode: every word it emits must decode to the intended control signals.
- Used by the program loader/boot path and by test infrastructure to build programs in hardware.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- BASE_ADDR, 0, word address loaded into the write pointer on reset and on start.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  reload write pointer to BASE_ADDR and clear count/err; honored only in IDLE
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_op  in  5  op kind (enum op_e)
- in_rd, in_rn, in_rm, in_rs  in  4 each  register fields
- in_imm  in  12  immediate (LSL uses [4:0])
- in_target  in  ADDR_W+2  branch target, byte address
- mem_we  out  1  write strobe, held until mem_ack
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded word
- mem_ack  in  1  memory accepted write
- count  out  ADDR_W+1  words written since start
- full  out  1  pointer past last word
- err  out  1  sticky error
- err_code  out  2  0 none, 1 illegal op, 2 imm range, 3 branch range/alignment

Behaviour:
- Reset (async): state=IDLE; in_ready=0 during reset; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; count=0; full=0; err=0; err_code=0.
- FSM has three states: IDLE, ENC, WRITE.
- IDLE: in_ready = !full.
  - On accept, latch all fields and go to ENC.
  - start has priority over a simultaneous in_valid: it reloads the pointer, clears count/err/full, and accepts nothing that cycle.
- ENC (1 cycle): compute the word and checks into mem_wdata.
  - On error: set err and err_code (first error wins), skip the write, return to IDLE.
  - Otherwise go to WRITE.
- WRITE: mem_we=1 with stable addr/data until mem_ack.
  - On the ack cycle: pointer+1, count+1, mem_we drops, return to IDLE.
  - full=1 when pointer wraps to BASE_ADDR+2^ADDR_W (pointer is ADDR_W+1 bits internally).
- Latency: accept at cycle n; mem_we first high at n+2. Throughput is 1 word per 3 cycles when mem_ack is tied high.
- Encodings (cond AL=E unless noted):
  - MOV_R: E1A0_d0_0m.
  - LSL_I: E1A0 d, shamt<<7, m. Error if imm[11:5]!=0 or shamt==0.
  - LSL_R: E1A0 d, s<<8 | 0x10 | m.
  - MOV_I: E3A0 d imm.
  - ADD_R: E08 n d 00m. ADD_I: E28 n d imm.
  - SUB_R: E04. SUB_I: E24.
  - MUL: E00 d 0 s 9 m.
  - AND_I: E20 n d imm.
  - CMP_R: E15 n 0 00m. CMP_I: E35 n 0 imm.
  - LDR_I: E59 n d imm. LDR_R: E79 n d 00m. STR_I: E58 n d imm.
  - PUSH: E52D d 004. POP: E49D d 004.
  - BX LR: E12FFF1E.
  - B/BEQ/BNE/BGT/BLT/BGE/BLE/BL: cond nibble E/0/1/C/B/A/D, then A (EB for BL), then off24.
- Branch offset: off = (in_target - ({mem_addr,2'b00}+8)) >>> 2.
  - Error 3 if in_target[1:0]!=0 or off does not fit signed 24 bits.
- Unused op_e codes produce error 1.
- Error state persists across later successful writes until start or rst.
- Reset mid-WRITE: mem_we drops asynchronously; the partial word is not counted.

Decomposition:
- Package encoder_pkg holds:
  - op_e enum (26 ops, 5 bits)
  - cond nibble constants
  - opcode-prefix constants, e.g. OPC_ADD_R=12'hE08, OPC_PUSH=12'hE52
  - err_e
- These constants are shared with the control-unit testbench.
- Sub-module instr_word_format: purely combinational field packer and range checker (op, fields, pc → word, err_code). The FSM and counters stay in the top module.

Test Plan:
- MOV_I r1,#5 at addr 0, mem_ack tied 1 → mem_wdata=E3A01005 on mem_addr 0; count=1; mem_we high exactly cycle n+2.
- ADD_R r2,r1,r3 then MUL r0,r1,r2 → E0812003 then E0000291 at addrs 0,1; mem_ack delayed 3 cycles on the first → in_ready stays 0 until ack.
- B at addr 0 with target 0x10 → EA000002; BL at addr 4 (byte 0x10) with target 0x0 → EBFFFFFA; BX → E12FFF1E.
- LSL_R r0,r1,r2 → E1A00211. PUSH r4 → E52D4004. POP r4 → E49D4004.
- LSL_I with imm=0x40 → no write, err=1, err_code=2; following MOV_R still writes and err stays 1; start clears it.
- ADDR_W=2: four writes → full=1, in_ready=0; rst asserted while mem_we=1 → mem_we=0 immediately, count=0.
